// File: rtl/ntt_job_scheduler_if.sv
// Handshake and twiddle-address bundle between the NTT job scheduler, its two
// requesters and the shared NTT/INTT operation module.
interface ntt_job_scheduler_if;
    logic [1:0] req;
    logic [2:0] req_mode0;
    logic [2:0] req_mode1;
    logic [1:0] gnt;
    logic       busy;
    logic       job_done;
    logic       job_err;
    logic       op_start;
    logic [2:0] op_mode;
    logic       op_done;
    logic [8:0] zeta_new_1;
    logic [8:0] zeta_new_2;
    logic [8:0] zeta_new_3;
    logic [8:0] zeta_new_4;
    logic [8:0] zeta_new_5;
    logic [8:0] zeta_new_2_delay;
    logic [8:0] zeta_new_3_delay;
    logic [8:0] zeta_new_4_delay;
    logic [8:0] zeta_new_5_delay;
    logic       spurious;
    logic [2:0] dbg_state;

    // req is a level held until gnt; gnt stays up for the whole job and drops
    // in the job_done cycle; op_start and op_done are single-cycle pulses.
    modport master (
        input  req, req_mode0, req_mode1, op_done,
        output gnt, busy, job_done, job_err, op_start, op_mode,
               zeta_new_1, zeta_new_2, zeta_new_3, zeta_new_4, zeta_new_5,
               zeta_new_2_delay, zeta_new_3_delay, zeta_new_4_delay, zeta_new_5_delay,
               spurious, dbg_state
    );

    modport slave (
        output req, req_mode0, req_mode1, op_done,
        input  gnt, busy, job_done, job_err, op_start, op_mode,
               zeta_new_1, zeta_new_2, zeta_new_3, zeta_new_4, zeta_new_5,
               zeta_new_2_delay, zeta_new_3_delay, zeta_new_4_delay, zeta_new_5_delay,
               spurious, dbg_state
    );
endinterface

// File: rtl/ntt_job_scheduler.sv
// Round-robin job scheduler for the shared NTT/INTT operation module with LFSR
// twiddle randomisation. Optional per-pass watchdog: define NTT_SCHED_WDT_EN.
module ntt_job_scheduler #(
    parameter int          PASSES     = 4,
    parameter int          GAP        = 2,
    parameter int          ZDLY       = 3,
    parameter logic [31:0] SEED       = 32'h1ACE_B00C,
    parameter int          WDT_CYCLES = 1024
) (
    input logic               clk,
    input logic               rst,
    ntt_job_scheduler_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_GAP, S_DONE} state_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    state_e      state_q, state_d;
    logic [3:0]  pass_cnt_q, pass_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [2:0]  mode_q, mode_d;
    logic        job_err_q, job_err_d;
    logic        spurious_q, spurious_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [8:0]  zeta_q [5];
    logic [8:0]  zeta_d [5];
    logic [35:0] dly_q [ZDLY];
    logic [35:0] dly_d [ZDLY];
    logic        wdt_hit;

`ifdef NTT_SCHED_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;

    assign wdt_hit = (state_q == S_RUN) && (wdt_q == WDT_W'(WDT_CYCLES - 1));

    always_comb begin
        wdt_d = '0;
        if (state_q == S_RUN && state_d == S_RUN && !bus.op_done) wdt_d = wdt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdt_q <= '0;
        else     wdt_q <= wdt_d;
    end
`else
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mode_d     = mode_q;
        job_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    // On a tie the requester that was not served last wins.
                    owner_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    mode_d  = owner_d ? bus.req_mode1 : bus.req_mode0;
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (mode_q > 3'd1) begin
                    state_d   = S_DONE;
                    job_err_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.op_done) begin
                    if (pass_cnt_q == 4'(PASSES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 4'd1;
                        gap_cnt_d  = '0;
                        state_d    = S_GAP;
                    end
                end else if (wdt_hit) begin
                    state_d   = S_DONE;
                    job_err_d = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'(GAP)) state_d = S_START;
                else                      gap_cnt_d = gap_cnt_q + 4'd1;
            end
            S_DONE: begin
                last_d     = owner_q;
                pass_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) gnt_d = '0;
    end

    always_comb begin
        spurious_d = spurious_q | (bus.op_done && state_q != S_RUN);
        lfsr_d     = lfsr_q;
        if (state_q == S_RUN)
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        zeta_d[0] = lfsr_q[8:0];
        zeta_d[1] = lfsr_q[17:9];
        zeta_d[2] = lfsr_q[26:18];
        zeta_d[3] = lfsr_q[31:23];
        zeta_d[4] = lfsr_q[8:0] ^ lfsr_q[31:23];
        dly_d[0]  = {zeta_q[1], zeta_q[2], zeta_q[3], zeta_q[4]};
        for (int i = 1; i < ZDLY; i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pass_cnt_q <= '0;
            gap_cnt_q  <= '0;
            gnt_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            mode_q     <= '0;
            job_err_q  <= 1'b0;
            spurious_q <= 1'b0;
            lfsr_q     <= SEED;
            for (int i = 0; i < 5; i++)    zeta_q[i] <= '0;
            for (int i = 0; i < ZDLY; i++) dly_q[i]  <= '0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            job_err_q  <= job_err_d;
            spurious_q <= spurious_d;
            lfsr_q     <= lfsr_d;
            for (int i = 0; i < 5; i++)    zeta_q[i] <= zeta_d[i];
            for (int i = 0; i < ZDLY; i++) dly_q[i]  <= dly_d[i];
        end
    end

    assign bus.gnt              = gnt_q;
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.job_done         = (state_q == S_DONE);
    assign bus.job_err          = job_err_q;
    assign bus.op_start         = (state_q == S_START) && (mode_q <= 3'd1);
    assign bus.op_mode          = mode_q;
    assign bus.spurious         = spurious_q;
    assign bus.dbg_state        = state_q;
    assign bus.zeta_new_1       = zeta_q[0];
    assign bus.zeta_new_2       = zeta_q[1];
    assign bus.zeta_new_3       = zeta_q[2];
    assign bus.zeta_new_4       = zeta_q[3];
    assign bus.zeta_new_5       = zeta_q[4];
    assign bus.zeta_new_2_delay = dly_q[ZDLY-1][35:27];
    assign bus.zeta_new_3_delay = dly_q[ZDLY-1][26:18];
    assign bus.zeta_new_4_delay = dly_q[ZDLY-1][17:9];
    assign bus.zeta_new_5_delay = dly_q[ZDLY-1][8:0];
endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed bench for ntt_job_scheduler: arbitration, pass sequencing, mode
// rejection, spurious op_done, mid-job reset, LFSR/delay line and watchdog.
module tb_ntt_job_scheduler;
    localparam int PASSES = 4;
    localparam int GAP    = 2;
    localparam int ZDLY   = 3;
`ifdef NTT_SCHED_WDT_EN
    localparam int TB_WDT = 16;
`else
    localparam int TB_WDT = 1024;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic [8:0] exp_q[$];

    ntt_job_scheduler_if bus();

    ntt_job_scheduler #(
        .PASSES(PASSES), .GAP(GAP), .ZDLY(ZDLY),
        .SEED(32'h1ACE_B00C), .WDT_CYCLES(TB_WDT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serves every pass of the granted job with op_done 20 cycles after op_start.
    // abort_at >= 0 returns 3 cycles into the RUN of that pass index.
    task automatic run_job(input string tag, input logic [1:0] eg, input logic [2:0] em,
                           input int exp_starts, input bit spur_gap, input int abort_at);
        int  starts;
        int  last_done;
        int  waited;
        bit  finished;
        starts    = 0;
        last_done = -1;
        finished  = 1'b0;
        while (!finished) begin
            waited = 0;
            while (!bus.op_start && !bus.job_done && waited < 200) begin
                tick();
                waited++;
            end
            if (waited >= 200 || starts > 16) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                return;
            end
            if (bus.job_done) begin
                check({tag, "_starts"}, starts, exp_starts);
                check({tag, "_done_lat"}, cyc - last_done, 1);
                check({tag, "_err"}, bus.job_err, 1'b0);
                check({tag, "_gnt_done"}, bus.gnt, 2'b00);
                tick();
                finished = 1'b1;
            end else begin
                check({tag, "_gnt"}, bus.gnt, eg);
                check({tag, "_mode"}, bus.op_mode, em);
                if (last_done >= 0) check({tag, "_gap"}, cyc - last_done, GAP + 2);
                if (starts == abort_at) begin
                    repeat (3) tick();
                    return;
                end
                starts++;
                repeat (20) tick();
                bus.op_done = 1'b1;
                last_done   = cyc;
                tick();
                bus.op_done = 1'b0;
                if (spur_gap && starts == 1) begin
                    bus.op_done = 1'b1;
                    tick();
                    bus.op_done = 1'b0;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.req_mode0 = 3'd0;
        bus.req_mode1 = 3'd0;
        bus.op_done   = 1'b0;
        #1;
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.job_done, 1'b0);
        check("rst_start", bus.op_start, 1'b0);
        check("rst_spur", bus.spurious, 1'b0);
        check("rst_z1", bus.zeta_new_1, 9'h000);
        check("rst_z5d", bus.zeta_new_5_delay, 9'h000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("seed_z1", bus.zeta_new_1, 9'h00C);
        check("seed_z2", bus.zeta_new_2, 9'h158);

        // single requester, NTT, full pass sequence
        bus.req = 2'b01;
        tick();
        check("t1_op_start", bus.op_start, 1'b1);
        bus.req = 2'b00;
        run_job("t1", 2'b01, 3'd0, PASSES, 1'b0, -1);

        // both requesters held: grants alternate starting with requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req       = 2'b11;
        bus.req_mode0 = 3'd0;
        bus.req_mode1 = 3'd1;
        run_job("t2a", 2'b01, 3'd0, PASSES, 1'b0, -1);
        run_job("t2b", 2'b10, 3'd1, PASSES, 1'b0, -1);
        run_job("t2c", 2'b01, 3'd0, PASSES, 1'b0, -1);
        bus.req = 2'b00;

        // illegal mode from requester 1 is rejected without op_start
        bus.req_mode1 = 3'd5;
        bus.req       = 2'b10;
        tick();
        check("t3_gnt", bus.gnt, 2'b10);
        check("t3_no_start", bus.op_start, 1'b0);
        bus.req = 2'b00;
        tick();
        check("t3_done", bus.job_done, 1'b1);
        check("t3_err", bus.job_err, 1'b1);
        check("t3_gnt_clr", bus.gnt, 2'b00);
        check("t3_no_start2", bus.op_start, 1'b0);
        tick();
        check("t3_done_pulse", bus.job_done, 1'b0);
        bus.req_mode0 = 3'd1;
        bus.req       = 2'b01;
        run_job("t3b", 2'b01, 3'd1, PASSES, 1'b0, -1);
        bus.req = 2'b00;

        // stray op_done in IDLE and in GAP
        check("t4_spur0", bus.spurious, 1'b0);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        check("t4_spur_idle", bus.spurious, 1'b1);
        check("t4_busy", bus.busy, 1'b0);
        bus.req_mode0 = 3'd0;
        bus.req       = 2'b01;
        run_job("t4", 2'b01, 3'd0, PASSES, 1'b1, -1);
        bus.req = 2'b00;
        check("t4_spur_sticky", bus.spurious, 1'b1);

        // reset during RUN of pass 2
        bus.req = 2'b01;
        run_job("t5a", 2'b01, 3'd0, PASSES, 1'b0, 2);
        bus.req = 2'b00;
        check("t5_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_gnt", bus.gnt, 2'b00);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_start", bus.op_start, 1'b0);
        check("t5_spur", bus.spurious, 1'b0);
        check("t5_z5d", bus.zeta_new_5_delay, 9'h000);
        tick();
        rst = 1'b0;
        tick();
        check("t5_seed_z1", bus.zeta_new_1, 9'h00C);
        check("t5_seed_z2", bus.zeta_new_2, 9'h158);

        // LFSR sequence and delay line across the first RUN cycles
        bus.req = 2'b01;
        tick();
        check("t5_op_start", bus.op_start, 1'b1);
        bus.req = 2'b00;
        exp_q.delete();
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) tick();
            if (i == 2) check("lfsr_z1_l0", bus.zeta_new_1, 9'h00C);
            if (i == 5) begin
                check("lfsr_z1_l3", bus.zeta_new_1, 9'h002);
                check("lfsr_z2_l3", bus.zeta_new_2, 9'h0EB);
                check("lfsr_z3_l3", bus.zeta_new_3, 9'h0DE);
                check("lfsr_z4_l3", bus.zeta_new_4, 9'h106);
                check("lfsr_z5_l3", bus.zeta_new_5, 9'h104);
            end
            exp_q.push_back(bus.zeta_new_2);
            if (exp_q.size() > ZDLY) check("z2_delay", bus.zeta_new_2_delay, exp_q.pop_front());
        end
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        run_job("t5b", 2'b01, 3'd0, PASSES - 1, 1'b0, -1);

`ifdef NTT_SCHED_WDT_EN
        begin
            int n;
            bus.req = 2'b01;
            tick();
            bus.req = 2'b00;
            n = 0;
            while (!bus.job_done && n < 40) begin
                tick();
                n++;
            end
            check("wdt_lat", n, 17);
            check("wdt_err", bus.job_err, 1'b1);
            tick();
            check("wdt_spur0", bus.spurious, 1'b0);
            bus.op_done = 1'b1;
            tick();
            bus.op_done = 1'b0;
            check("wdt_spur", bus.spurious, 1'b1);
        end
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
